seg7_scan_driver: RTL and testbench

Time-multiplexed seven-segment display driver for the board's user-output path. It takes a hex value from the processor and scans it onto NUM_DIGITS common-anode/cathode digits, one digit at a time. A guard (all-off) interval between digits suppresses ghosting. Updates are double-buffered and applied only at frame boundaries, so a displayed frame never tears.

---
 rtl/seg7_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed seven-segment display driver. A hex value is latched into a
// shadow register on load and copied into the display register only at frame
// boundaries, so a frame never tears. Each digit slot starts with an all-off
// guard interval to suppress ghosting.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   value       hex nibbles, value[3:0] is digit 0 (rightmost, an[0])
//   dp_in       decimal-point request per digit
//   load        strobe: latch value/dp_in into the shadow register
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the active digit
//   an          digit enables, one-hot while a digit is on
//   frame_start one-cycle pulse after the display register is updated
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned REFRESH_TICKS = 10000,
   parameter int unsigned GUARD_TICKS   = 500,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter bit          LZ_SUPPRESS   = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      load,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_start
);

   localparam int unsigned TickW  = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
   localparam int unsigned DigitW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [TickW-1:0]  TickLast   = TickW'(REFRESH_TICKS - 1);
   localparam logic [TickW-1:0]  GuardTicks = TickW'(GUARD_TICKS);
   localparam logic [DigitW-1:0] DigitLast  = DigitW'(NUM_DIGITS - 1);

   typedef enum logic {StGuard, StOn} state_e;

   localparam state_e StReset = (GUARD_TICKS == 0) ? StOn : StGuard;

   logic [4*NUM_DIGITS-1:0] shadow_val_q, disp_val_q;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
   logic [TickW-1:0]        tick_q, tick_d;
   logic [DigitW-1:0]       digit_q, digit_d;
   state_e                  state_q, state_d;

   logic                    tick_wrap, frame_end;
   logic [3:0]              nibble;
   logic                    dp_sel, zero_hi, blank;
   logic [6:0]              seg_h;
   logic [NUM_DIGITS-1:0]   an_h;
   logic                    dp_h;

   function automatic logic [6:0] hex_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // Scan position and next guard/on state.
   always_comb begin
      tick_wrap = (tick_q == TickLast);
      frame_end = tick_wrap && (digit_q == DigitLast);
      tick_d    = tick_wrap ? '0 : tick_q + 1'b1;
      digit_d   = digit_q;
      if (tick_wrap) begin
         digit_d = (digit_q == DigitLast) ? '0 : digit_q + 1'b1;
      end
      state_d = (tick_d < GuardTicks) ? StGuard : StOn;
   end

   // Active-high view of the outputs for the current scan position.
   always_comb begin
      nibble = 4'h0;
      dp_sel = 1'b0;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         if (digit_q == DigitW'(k)) begin
            nibble = disp_val_q[4*k +: 4];
            dp_sel = disp_dp_q[k];
         end
      end
      // Walk down from the top digit; a digit blanks while everything at and
      // above it is zero. Digit 0 is never considered.
      zero_hi = 1'b1;
      blank   = 1'b0;
      for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
         zero_hi = zero_hi & (disp_val_q[4*k +: 4] == 4'h0);
         if (digit_q == DigitW'(k)) begin
            blank = zero_hi;
         end
      end
      seg_h = '0;
      an_h  = '0;
      dp_h  = 1'b0;
      if (state_q == StOn) begin
         an_h  = NUM_DIGITS'(1) << digit_q;
         seg_h = (LZ_SUPPRESS && blank) ? 7'b0000000 : hex_decode(nibble);
         dp_h  = dp_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         tick_q       <= '0;
         digit_q      <= '0;
         state_q      <= StReset;
         seg          <= {7{ACTIVE_LOW}};
         an           <= {NUM_DIGITS{ACTIVE_LOW}};
         dp           <= ACTIVE_LOW;
         frame_start  <= 1'b0;
      end else begin
         if (load) begin
            shadow_val_q <= value;
            shadow_dp_q  <= dp_in;
         end
         // Non-blocking update means a same-edge load is seen one frame later.
         if (frame_end) begin
            disp_val_q <= shadow_val_q;
            disp_dp_q  <= shadow_dp_q;
         end
         tick_q      <= tick_d;
         digit_q     <= digit_d;
         state_q     <= state_d;
         seg         <= seg_h ^ {7{ACTIVE_LOW}};
         an          <= an_h ^ {NUM_DIGITS{ACTIVE_LOW}};
         dp          <= dp_h ^ ACTIVE_LOW;
         frame_start <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver. Three instances share one stimulus stream:
// dut_a (guard 2, active-low), dut_lz (leading-zero suppression) and dut_g0
// (no guard, active-high). A frame-position reference model predicts outputs.
module tb_seg7_scan_driver;

   localparam int R  = 8;
   localparam int N  = 4;
   localparam int NR = N * R;

   localparam logic [6:0] HEX_TAB [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;

   logic [6:0]  seg_a, seg_lz, seg_g0;
   logic [3:0]  an_a, an_lz, an_g0;
   logic        dp_a, dp_lz, dp_g0;
   logic        fs_a, fs_lz, fs_g0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_TICKS(8), .GUARD_TICKS(2),
                      .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b0)) dut_a (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
      .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a));

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_TICKS(8), .GUARD_TICKS(2),
                      .ACTIVE_LOW(1'b1), .LZ_SUPPRESS(1'b1)) dut_lz (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
      .seg(seg_lz), .dp(dp_lz), .an(an_lz), .frame_start(fs_lz));

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_TICKS(8), .GUARD_TICKS(0),
                      .ACTIVE_LOW(1'b0), .LZ_SUPPRESS(1'b0)) dut_g0 (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
      .seg(seg_g0), .dp(dp_g0), .an(an_g0), .frame_start(fs_g0));

   // ---------------- reference model ----------------
   // Position within the frame, 0..NR-1: digit = pos / R, tick = pos % R.
   int          m_pos;
   logic [15:0] m_sh_val, m_disp_val;
   logic [3:0]  m_sh_dp, m_disp_dp;
   logic [11:0] exp_a, exp_lz, exp_g0;  // {seg, an, dp}
   logic        exp_fs;

   function automatic logic [11:0] model_out(int guard, bit al, bit lz, int pos,
                                             logic [15:0] v, logic [3:0] d);
      int         k = pos / R;
      int         t = pos % R;
      logic [6:0] s = '0;
      logic [3:0] a = '0;
      logic       p = 1'b0;
      logic [15:0] hi;
      if (t >= guard) begin
         hi = v >> (4 * k);
         a  = 4'(1 << k);
         s  = (lz && k > 0 && hi == 16'h0) ? 7'h00 : HEX_TAB[v[4*k +: 4]];
         p  = d[k];
      end
      return al ? ~{s, a, p} : {s, a, p};
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_pos      <= 0;
         m_sh_val   <= '0;
         m_sh_dp    <= '0;
         m_disp_val <= '0;
         m_disp_dp  <= '0;
         exp_a      <= 12'hFFF;
         exp_lz     <= 12'hFFF;
         exp_g0     <= 12'h000;
         exp_fs     <= 1'b0;
      end else begin
         if (load) begin
            m_sh_val <= value;
            m_sh_dp  <= dp_in;
         end
         if (m_pos == NR - 1) begin
            m_disp_val <= m_sh_val;
            m_disp_dp  <= m_sh_dp;
         end
         exp_fs <= (m_pos == NR - 1);
         exp_a  <= model_out(2, 1'b1, 1'b0, m_pos, m_disp_val, m_disp_dp);
         exp_lz <= model_out(2, 1'b1, 1'b1, m_pos, m_disp_val, m_disp_dp);
         exp_g0 <= model_out(0, 1'b0, 1'b0, m_pos, m_disp_val, m_disp_dp);
         m_pos  <= (m_pos + 1) % NR;
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({seg_a, an_a, dp_a, fs_a} !== 13'h1FFE || {seg_g0, an_g0, dp_g0} !== 12'h000) begin
         errors++;
         $display("FAIL reset_hold a=%h g0=%h", {seg_a, an_a, dp_a, fs_a}, {seg_g0, an_g0, dp_g0});
      end
      reset = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         checks++;
         if (n < 3 && {seg_a, an_a, dp_a, fs_a} !== 13'h1FFE) begin
            errors++;
            $display("FAIL reset_inactive n=%0d got=%h exp=1ffe", n, {seg_a, an_a, dp_a, fs_a});
         end
         if (n == 3 && {seg_a, an_a, dp_a} !== {7'h40, 4'hE, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_on got=%h exp=%h", {seg_a, an_a, dp_a}, {7'h40, 4'hE, 1'b1});
         end
      end
   endtask

   task automatic wait_frame(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fs_a && n < 3 * NR);
      checks++;
      if (!fs_a) begin
         errors++;
         $display("FAIL %s frame_start_timeout got=0 exp=1", name);
      end
   endtask

   task automatic test_load_basic();
      int hits = 0;
      @(negedge clk);
      value = 16'h1234; dp_in = 4'h0; load = 1'b1;
      @(negedge clk);
      load = 1'b0; value = 16'hFFFF;  // no effect without load
      wait_frame("load_basic");
      for (int c = 0; c < NR; c++) begin
         @(negedge clk);
         checks++;
         if ({seg_a, an_a, dp_a, fs_a} !== {exp_a, exp_fs}) begin
            errors++;
            $display("FAIL load_basic cyc=%0d got=%h exp=%h", c, {seg_a, an_a, dp_a, fs_a},
                     {exp_a, exp_fs});
         end
         if (an_a == 4'hE && seg_a == 7'b0011001) hits++;
      end
      checks++;
      if (hits != 6) begin
         errors++;
         $display("FAIL load_basic_digit0_slots got=%0d exp=6", hits);
      end
   endtask

   task automatic test_load_at_boundary();
      int hits_old = 0;
      int hits_new = 0;
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_pos != NR - 1 && n < 2 * NR);
      value = 16'hAAAA; dp_in = 4'h0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      for (int c = 0; c < 2 * NR; c++) begin
         @(negedge clk);
         checks++;
         if ({seg_a, an_a, dp_a, fs_a} !== {exp_a, exp_fs}) begin
            errors++;
            $display("FAIL boundary cyc=%0d got=%h exp=%h", c, {seg_a, an_a, dp_a, fs_a},
                     {exp_a, exp_fs});
         end
         if (c < NR && an_a == 4'hE && seg_a == 7'b0011001) hits_old++;
         if (c >= NR && an_a == 4'hE && seg_a == 7'b0001000) hits_new++;
      end
      checks++;
      if (hits_old != 6 || hits_new != 6) begin
         errors++;
         $display("FAIL boundary_order got old=%0d new=%0d exp 6/6", hits_old, hits_new);
      end
   endtask

   task automatic test_lz_suppress();
      int h3 = 0, h2 = 0, h1 = 0, h0 = 0;
      @(negedge clk);
      value = 16'h0050; dp_in = 4'b0100; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame("lz");
      for (int c = 0; c < NR; c++) begin
         @(negedge clk);
         checks++;
         if ({seg_lz, an_lz, dp_lz, fs_lz} !== {exp_lz, exp_fs}) begin
            errors++;
            $display("FAIL lz cyc=%0d got=%h exp=%h", c, {seg_lz, an_lz, dp_lz, fs_lz},
                     {exp_lz, exp_fs});
         end
         if (an_lz == 4'b0111 && seg_lz == 7'h7F && dp_lz) h3++;
         if (an_lz == 4'b1011 && seg_lz == 7'h7F && !dp_lz) h2++;
         if (an_lz == 4'b1101 && seg_lz == 7'b0010010) h1++;
         if (an_lz == 4'b1110 && seg_lz == 7'b1000000) h0++;
      end
      checks++;
      if (h3 != 6 || h2 != 6 || h1 != 6 || h0 != 6) begin
         errors++;
         $display("FAIL lz_digits got=%0d/%0d/%0d/%0d exp=6/6/6/6", h3, h2, h1, h0);
      end
   endtask

   task automatic test_no_guard();
      @(negedge clk);
      value = 16'h8888; dp_in = 4'h0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_frame("no_guard");
      for (int c = 0; c < NR; c++) begin
         @(negedge clk);
         checks++;
         if (seg_g0 !== 7'h7F || an_g0 !== 4'(1 << (c / R))) begin
            errors++;
            $display("FAIL no_guard cyc=%0d got seg=%h an=%h exp seg=7f an=%h", c, seg_g0,
                     an_g0, 4'(1 << (c / R)));
         end
         checks++;
         if ({seg_g0, an_g0, dp_g0, fs_g0} !== {exp_g0, exp_fs}) begin
            errors++;
            $display("FAIL no_guard_model cyc=%0d got=%h exp=%h", c,
                     {seg_g0, an_g0, dp_g0, fs_g0}, {exp_g0, exp_fs});
         end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int first_fs = -1;
      do begin
         @(negedge clk);
         n++;
      end while (m_pos != 2 * R + 4 && n < 2 * NR);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({seg_a, an_a, dp_a, fs_a} !== 13'h1FFE || {seg_g0, an_g0, dp_g0} !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid_inactive a=%h g0=%h", {seg_a, an_a, dp_a, fs_a},
                  {seg_g0, an_g0, dp_g0});
      end
      reset = 1'b0;
      for (int c = 1; c <= NR + 4; c++) begin
         @(negedge clk);
         if (fs_a && first_fs < 0) first_fs = c;
         checks++;
         if ({seg_a, an_a, dp_a, fs_a} !== {exp_a, exp_fs}) begin
            errors++;
            $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, {seg_a, an_a, dp_a, fs_a},
                     {exp_a, exp_fs});
         end
         if (c == 3 || c == NR + 3) begin
            checks++;
            if ({seg_a, an_a} !== {7'h40, 4'hE}) begin
               errors++;
               $display("FAIL reset_mid_zero cyc=%0d got=%h exp=40e", c, {seg_a, an_a});
            end
         end
      end
      checks++;
      if (first_fs != NR) begin
         errors++;
         $display("FAIL reset_mid_first_fs got=%0d exp=%0d", first_fs, NR);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 16; it++) begin
         int gap = $urandom_range(1, 40);
         for (int c = 0; c < gap; c++) begin
            @(negedge clk);
            checks++;
            if ({seg_a, an_a, dp_a, fs_a} !== {exp_a, exp_fs} ||
                {seg_lz, an_lz, dp_lz, fs_lz} !== {exp_lz, exp_fs} ||
                {seg_g0, an_g0, dp_g0, fs_g0} !== {exp_g0, exp_fs}) begin
               errors++;
               $display("FAIL random it=%0d got=%h/%h/%h exp=%h/%h/%h fs=%b", it,
                        {seg_a, an_a, dp_a}, {seg_lz, an_lz, dp_lz}, {seg_g0, an_g0, dp_g0},
                        exp_a, exp_lz, exp_g0, exp_fs);
            end
            load = 1'b0;
            for (int k = 0; k < 4; k++) value[4*k +: 4] = ($urandom_range(0, 1) != 0) ?
                                                         4'($urandom) : 4'h0;
            dp_in = 4'($urandom);
            if ($urandom_range(0, 3) == 0) load = 1'b1;
         end
      end
      @(negedge clk);
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_load_at_boundary();
      test_lz_suppress();
      test_no_guard();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
